// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the five-stage CPU.
// Arbitrates ID/EX/MEM stall requests and exception flushes. Sequences
// multi-cycle EX operations with a down-counter. Keeps a saturating count
// of stalled cycles.
module pipe_ctrl #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_mem,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_len,
    input  logic              exc_valid,
    input  logic [31:0]       exc_pc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_done,
    output logic              mc_busy,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             ex_stall;

    // EX holds the pipe from the start cycle through the last RUN cycle
    always_comb begin
        ex_stall = ((state == S_IDLE) && ex_mc_start) || (state == S_RUN);
    end

    // Prioritised stall vector and exception redirect
    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (exc_valid) begin
            flush  = 1'b1;
            new_pc = exc_pc;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (ex_stall) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end
    end

    // Status outputs; an exception suppresses a pending result
    always_comb begin
        mc_done = (state == S_DONE) && !exc_valid;
        mc_busy = (state != S_IDLE);
    end

    // Multi-cycle sequencer; the unit keeps counting through memory stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (exc_valid) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_mc_start) begin
                        state <= S_RUN;
                        cnt   <= (ex_mc_len == '0) ? CNT_ONE : ex_mc_len;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stallreq_mem) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles with any stage held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
        end else if ((stall != '0) && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + PERF_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test of pipe_ctrl with hand-computed expectations.
// A second instance with a 4-bit performance counter shares all inputs so
// saturation can be observed.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_len;
    logic        exc_valid;
    logic [31:0] exc_pc;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_done;
    logic        mc_busy;
    logic [31:0] perf32;

    logic [5:0]  stall4;
    logic        flush4;
    logic [31:0] new_pc4;
    logic        mc_done4;
    logic        mc_busy4;
    logic [3:0]  perf4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_perf = 0;

    pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .mc_done(mc_done), .mc_busy(mc_busy), .perf_stall_cycles(perf32)
    );

    pipe_ctrl #(.CNT_W(6), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .stall(stall4), .flush(flush4), .new_pc(new_pc4),
        .mc_done(mc_done4), .mc_busy(mc_busy4), .perf_stall_cycles(perf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_perf(input string tag);
        check({tag, "_perf32"}, 64'(perf32), 64'(exp_perf));
        check({tag, "_perf4"}, 64'(perf4), 64'((exp_perf > 15) ? 15 : exp_perf));
    endtask

    // Advance one clock; 'stalled' says whether the cycle just ending had stall!=0
    task automatic step(input bit stalled);
        @(posedge clk);
        #1;
        if (stalled && rst) exp_perf++;
    endtask

    initial begin
        rst = 1'b0; stallreq_id = 0; stallreq_mem = 0; ex_mc_start = 0;
        ex_mc_len = '0; exc_valid = 0; exc_pc = '0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'h00);
        check("rst_busy", 64'(mc_busy), 64'd0);
        check("rst_perf", 64'(perf32), 64'd0);
        rst = 1'b1;
        #1;
        check("idle_stall", 64'(stall), 64'h00);
        check("idle_flush", 64'(flush), 64'd0);
        check("idle_newpc", 64'(new_pc), 64'd0);
        check("idle_done", 64'(mc_done), 64'd0);
        check("idle_busy", 64'(mc_busy), 64'd0);
        step(0); step(0);
        check_perf("idle");

        // Multi-cycle op, len=4
        ex_mc_start = 1; ex_mc_len = 6'd4;
        #1;
        check("mc4_start_stall", 64'(stall), 64'h0F);
        check("mc4_start_busy", 64'(mc_busy), 64'd0);
        step(1);
        ex_mc_start = 0; ex_mc_len = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mc4_run_stall", 64'(stall), 64'h0F);
            check("mc4_run_busy", 64'(mc_busy), 64'd1);
            check("mc4_run_done", 64'(mc_done), 64'd0);
            step(1);
        end
        #1;
        check("mc4_done", 64'(mc_done), 64'd1);
        check("mc4_done_stall", 64'(stall), 64'h00);
        check("mc4_done_busy", 64'(mc_busy), 64'd1);
        check_perf("mc4");
        check("mc4_perf_const", 64'(perf32), 64'd5);
        step(0);
        #1;
        check("mc4_end_done", 64'(mc_done), 64'd0);
        check("mc4_end_busy", 64'(mc_busy), 64'd0);

        // Length zero behaves as length one
        ex_mc_start = 1; ex_mc_len = 6'd0;
        #1;
        check("len0_start", 64'(stall), 64'h0F);
        step(1);
        ex_mc_start = 0;
        #1;
        check("len0_run", 64'(stall), 64'h0F);
        check("len0_run_done", 64'(mc_done), 64'd0);
        step(1);
        #1;
        check("len0_done", 64'(mc_done), 64'd1);
        check("len0_done_stall", 64'(stall), 64'h00);
        step(0);
        #1;
        check("len0_end_busy", 64'(mc_busy), 64'd0);
        check_perf("len0");

        // Memory stall held across DONE
        ex_mc_start = 1; ex_mc_len = 6'd1;
        #1; step(1);
        ex_mc_start = 0;
        #1;
        check("memd_run", 64'(stall), 64'h0F);
        step(1);
        stallreq_mem = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("memd_stall", 64'(stall), 64'h1F);
            check("memd_done", 64'(mc_done), 64'd1);
            step(1);
        end
        stallreq_mem = 0;
        #1;
        check("memd_rel_done", 64'(mc_done), 64'd1);
        check("memd_rel_stall", 64'(stall), 64'h00);
        step(0);
        #1;
        check("memd_end_busy", 64'(mc_busy), 64'd0);
        check_perf("memd");

        // Exception at RUN cycle 2 of len=8
        ex_mc_start = 1; ex_mc_len = 6'd8;
        #1; step(1);
        ex_mc_start = 0;
        #1; step(1);
        exc_valid = 1; exc_pc = 32'h0000_0040;
        #1;
        check("exc_flush", 64'(flush), 64'd1);
        check("exc_newpc", 64'(new_pc), 64'h40);
        check("exc_stall", 64'(stall), 64'h00);
        check("exc_done", 64'(mc_done), 64'd0);
        check("exc_busy", 64'(mc_busy), 64'd1);
        step(0);
        exc_valid = 0; exc_pc = 32'h0000_1234;
        #1;
        check("exc_after_busy", 64'(mc_busy), 64'd0);
        check("exc_after_flush", 64'(flush), 64'd0);
        check("exc_after_newpc", 64'(new_pc), 64'd0);
        check_perf("exc");

        // Exception in DONE suppresses mc_done; perf4 reaches saturation here
        ex_mc_start = 1; ex_mc_len = 6'd1;
        #1; step(1);
        ex_mc_start = 0;
        #1; step(1);
        exc_valid = 1; exc_pc = 32'h0000_0080;
        #1;
        check("excd_done", 64'(mc_done), 64'd0);
        check("excd_flush", 64'(flush), 64'd1);
        check("excd_newpc", 64'(new_pc), 64'h80);
        step(0);
        exc_valid = 0; exc_pc = '0;
        #1;
        check("excd_busy", 64'(mc_busy), 64'd0);
        check_perf("excd");

        // Start dropped when coincident with an exception
        ex_mc_start = 1; ex_mc_len = 6'd3; exc_valid = 1;
        #1;
        check("stx_stall", 64'(stall), 64'h00);
        check("stx_flush", 64'(flush), 64'd1);
        step(0);
        ex_mc_start = 0; exc_valid = 0;
        #1;
        check("stx_busy", 64'(mc_busy), 64'd0);
        check("stx_stall2", 64'(stall), 64'h00);

        // Priority: ID under EX, EX under MEM, ID alone
        stallreq_id = 1; ex_mc_start = 1; ex_mc_len = 6'd1;
        #1;
        check("pri_id_ex", 64'(stall), 64'h0F);
        stallreq_mem = 1;
        #1;
        check("pri_id_ex_mem", 64'(stall), 64'h1F);
        step(1);
        stallreq_mem = 0; ex_mc_start = 0;
        #1;
        check("pri_run_id", 64'(stall), 64'h0F);
        check("pri_run_busy", 64'(mc_busy), 64'd1);
        step(1);
        #1;
        check("pri_done_id", 64'(stall), 64'h07);
        check("pri_done", 64'(mc_done), 64'd1);
        step(1);
        #1;
        check("pri_idle_id", 64'(stall), 64'h07);
        check("pri_idle_busy", 64'(mc_busy), 64'd0);
        step(1);
        stallreq_id = 0;
        check_perf("pri");

        // Start ignored outside IDLE
        ex_mc_start = 1; ex_mc_len = 6'd2;
        #1; step(1);
        ex_mc_len = 6'd10;
        #1;
        check("ign_run1", 64'(stall), 64'h0F);
        step(1);
        #1;
        check("ign_run2", 64'(stall), 64'h0F);
        step(1);
        #1;
        check("ign_done", 64'(mc_done), 64'd1);
        check("ign_done_stall", 64'(stall), 64'h00);
        step(0);
        ex_mc_start = 0;
        #1;
        check("ign_idle_stall", 64'(stall), 64'h00);
        check("ign_idle_busy", 64'(mc_busy), 64'd0);
        step(0);
        check_perf("ign");

        // Saturation: 20 further stalled cycles
        stallreq_id = 1;
        for (int i = 0; i < 20; i++) step(1);
        stallreq_id = 0;
        #1;
        check_perf("sat");
        check("sat_perf4_const", 64'(perf4), 64'd15);

        // Asynchronous reset mid-RUN
        ex_mc_start = 1; ex_mc_len = 6'd5;
        #1; step(1);
        ex_mc_start = 0;
        #1; step(1);
        #1;
        check("arun_busy_pre", 64'(mc_busy), 64'd1);
        rst = 0;
        #1;
        exp_perf = 0;
        check("arun_busy", 64'(mc_busy), 64'd0);
        check("arun_done", 64'(mc_done), 64'd0);
        check("arun_stall", 64'(stall), 64'h00);
        check_perf("arun");
        step(0);
        rst = 1;

        // Asynchronous reset mid-DONE
        ex_mc_start = 1; ex_mc_len = 6'd1;
        #1; step(1);
        ex_mc_start = 0;
        #1; step(1);
        #1;
        check("adone_pre", 64'(mc_done), 64'd1);
        rst = 0;
        #1;
        exp_perf = 0;
        check("adone_done", 64'(mc_done), 64'd0);
        check("adone_busy", 64'(mc_busy), 64'd0);
        check_perf("adone");
        step(0);
        rst = 1;
        #1;
        check("post_stall", 64'(stall), 64'h00);
        check("post_busy", 64'(mc_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
